// File: rtl/conv_fprop_div_pkg.sv
// conv_fprop_div_pkg: shared state encoding and default widths for the sequential unsigned divider
package conv_fprop_div_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
    localparam int DEF_DIVIDEND_WIDTH = 62;
    localparam int DEF_DIVISOR_WIDTH = 31;
    localparam int DEF_CNT_WIDTH = $clog2(DEF_DIVIDEND_WIDTH);
    function automatic int cnt_width(input int dividend_width);
        return $clog2(dividend_width);
    endfunction
endpackage

// File: rtl/conv_fprop_udiv_62ns_31ns_seq_if.sv
// conv_fprop_udiv_62ns_31ns_seq_if: operand/result handshake bundle between producer, divider and consumer
interface conv_fprop_udiv_62ns_31ns_seq_if #(
    parameter int DIVIDEND_WIDTH = 62,
    parameter int DIVISOR_WIDTH = 31
);
    logic in_valid;
    logic in_ready;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0] divisor;
    logic out_valid;
    logic out_ready;
    logic [DIVIDEND_WIDTH-1:0] quotient;
    logic [DIVISOR_WIDTH-1:0] remainder;
    logic div_by_zero;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/conv_fprop_udiv_step.sv
// conv_fprop_udiv_step: one combinational radix-2 restoring division iteration
module conv_fprop_udiv_step #(
    parameter int DIVISOR_WIDTH = 31
) (
    input  logic [DIVISOR_WIDTH-1:0] r,
    input  logic                     qmsb,
    input  logic [DIVISOR_WIDTH-1:0] d,
    output logic [DIVISOR_WIDTH-1:0] r_next,
    output logic                     qbit
);
    logic [DIVISOR_WIDTH:0] t;
    logic [DIVISOR_WIDTH:0] diff;
    always_comb begin
        t = {r, qmsb};
        diff = t - {1'b0, d};
        qbit = t >= {1'b0, d};
        // r < d keeps the restored remainder inside DIVISOR_WIDTH bits
        r_next = DIVISOR_WIDTH'(qbit ? diff : t);
    end
endmodule

// File: rtl/conv_fprop_udiv_62ns_31ns_seq.sv
// conv_fprop_udiv_62ns_31ns_seq: sequential restoring divider, one quotient bit per enabled cycle,
// valid/ready on both sides, global ce stall and synchronous active-low reset
module conv_fprop_udiv_62ns_31ns_seq
    import conv_fprop_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH = DEF_DIVISOR_WIDTH
) (
    input logic clk,
    input logic reset,
    input logic ce,
    conv_fprop_udiv_62ns_31ns_seq_if.slave bus
);
    localparam int CW = cnt_width(DIVIDEND_WIDTH);
    div_state_t state, nxt;
    logic [DIVIDEND_WIDTH-1:0] q;
    logic [DIVISOR_WIDTH-1:0] r, d, r_next;
    logic [CW-1:0] cnt;
    logic dz, qbit, last;
    conv_fprop_udiv_step #(.DIVISOR_WIDTH(DIVISOR_WIDTH)) u_step (
        .r(r),
        .qmsb(q[DIVIDEND_WIDTH-1]),
        .d(d),
        .r_next(r_next),
        .qbit(qbit)
    );
    assign last = cnt == CW'(DIVIDEND_WIDTH - 1);
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else if (ce) state <= nxt;
    end
    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (bus.in_valid ? BUSY : IDLE)
            : state == BUSY ? (last ? DONE : BUSY)
            : (bus.out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
            r <= '0;
            d <= '0;
            cnt <= '0;
            dz <= 1'b0;
        end else if (ce) begin
            if (state == IDLE && bus.in_valid) begin
                q <= bus.dividend;
                r <= '0;
                d <= bus.divisor;
                cnt <= '0;
                dz <= bus.divisor == '0;
            end else if (state == BUSY) begin
                q <= {q[DIVIDEND_WIDTH-2:0], qbit};
                r <= r_next;
                cnt <= cnt + 1'b1;
            end
        end
    end
    assign bus.in_ready = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.quotient = q;
    assign bus.remainder = r;
    assign bus.div_by_zero = dz;
endmodule

// File: doc/conv_fprop_udiv_62ns_31ns_seq.md
# conv_fprop_udiv_62ns_31ns_seq

Sequential unsigned divider for the conv_fprop datapath: it divides a 62-bit product-domain value by a 31-bit operand and returns quotient and remainder. It is the inverse of the pipelined 31×31→62 unsigned multiplier and is used where accumulated products are normalised back to operand scale. It implements radix-2 restoring division, one quotient bit per enabled cycle, with valid/ready handshakes on both sides and the HLS-style global `ce` stall.

## Interface
- `DIVIDEND_WIDTH`, default 62: dividend and quotient width.
- `DIVISOR_WIDTH`, default 31: divisor and remainder width; must be ≤ `DIVIDEND_WIDTH`.
- `clk` in 1: clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset; the only reset; has priority over `ce`.
- `ce` in 1: global clock enable; when low, no state or output changes.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block accepts operands.
- `dividend` in `DIVIDEND_WIDTH`: unsigned.
- `divisor` in `DIVISOR_WIDTH`: unsigned.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `quotient` out `DIVIDEND_WIDTH`: unsigned quotient.
- `remainder` out `DIVISOR_WIDTH`: unsigned remainder.
- `div_by_zero` out 1: the divisor of this result was 0.

## Operation
- States are `IDLE`, `BUSY` and `DONE`. `in_ready = (state==IDLE)`. `out_valid = (state==DONE)`.
- A transfer completes only on an edge with `ce=1`. Producer and consumer share the same `ce`.
- **IDLE**:
  - On `in_valid` (with `ce=1`), capture the dividend into shift register `Q`, the divisor into `D`, and set `R=0` and `cnt=0`.
  - Latch `dz = (divisor==0)`. Go to `BUSY`.
- **BUSY**: each enabled edge performs one iteration:
  - `t = {R[DW-1:0], Q[MSB]}`, with width `DIVISOR_WIDTH+1`.
  - `Q = {Q[MSB-1:0], (t >= {0,D})}`.
  - `R = (t >= {0,D}) ? t-D : t`.
  - `cnt++`.
  - On the iteration with `cnt == DIVIDEND_WIDTH-1`, go to `DONE`.
  - `R` never exceeds `D`, so no width overflow occurs.
- **DONE**:
  - `quotient=Q`, `remainder=R[DW-1:0]`, `div_by_zero=dz`. These are held stable until the result is taken.
  - On `out_ready` (with `ce=1`), go to `IDLE`.
- **Divide by zero**: the same iteration runs. The result is `quotient` = all ones, `remainder = dividend[DIVISOR_WIDTH-1:0]`, `div_by_zero=1`.
- `in_valid` outside `IDLE` is ignored. There is one operation in flight, with no queuing.
- **Reset low on any edge** (including mid-`BUSY` or `DONE`):
  - `state=IDLE`. The in-flight result is discarded.
  - `Q`, `R`, `D`, `cnt` and `dz` are cleared.
- **Reset values**: `in_ready=1`, `out_valid=0`, `quotient=0`, `remainder=0`, `div_by_zero=0`.

## Timing
- Call the capture edge E0. Iterations occur on the enabled edges E1..E62. `out_valid` is high after E62, which is exactly `DIVIDEND_WIDTH` enabled edges after capture.
- Latency does not depend on the data, including for a divisor of 0.
- `ce` low for N cycles anywhere delays completion by exactly N cycles.
- When the result is taken (`out_valid & out_ready` at edge Ek), `in_ready` is high after Ek. The next capture can happen at Ek+1.
- Minimum initiation interval: `DIVIDEND_WIDTH+2` cycles.
- `out_ready` held low keeps the block in `DONE` indefinitely with outputs stable.
- Handshake outputs are decoded from registered state only, with no combinational path from input to output.

## Structure
- Package `conv_fprop_div_pkg` holds:
  - the state enum (`IDLE`, `BUSY`, `DONE`);
  - the default width constants;
  - the counter width `$clog2(DIVIDEND_WIDTH)`.
- Sub-module `conv_fprop_udiv_step` is combinational: one restoring iteration, `(R, Qmsb, D) → (R', qbit)`.
- The top level holds the FSM, `Q`, `R`, `D`, `cnt` and `dz` registers.

## Test plan
- 1000 / 7 → `quotient=142`, `remainder=6`, `div_by_zero=0`; `out_valid` rises on the 62nd enabled edge after capture.
- (2^62−1) / (2^31−1) → `quotient = 2^31+1`, `remainder=0`.
- (2^62−1) / 1 → `quotient = 2^62−1`, `remainder=0`.
- 5 / 9 → `quotient=0`, `remainder=5`.
- 0x5 / 0 → `quotient` = all ones, `remainder=5`, `div_by_zero=1`, with the same latency as normal operands.
- Back-pressure: `out_ready` low for 10 cycles.
  - Required: `out_valid` and data hold, `in_ready=0`, and a second `in_valid` is ignored.
  - On release, the result is taken, `in_ready` is high next cycle, and a back-to-back operation completes correctly.
- `ce` low for 20 cycles in mid-`BUSY` → completion is delayed by exactly 20 cycles with a correct result.
- `reset` low for 1 cycle in mid-`BUSY` → `out_valid=0` and `in_ready=1` after that edge, and no stale result appears afterwards.
